// File: rtl/ltc5548_sys_debug_vjtag_pkg.sv
// Shared types and constants for the virtual-JTAG initiator that drives the
// Nios II debug slave.
package ltc5548_sys_debug_vjtag_pkg;

  localparam int DEF_DR_WIDTH = 38;
  localparam int DEF_IR_WIDTH = 2;

  // Debug slave virtual IR codes
  localparam logic [1:0] IR_OCIMEM   = 2'b00;
  localparam logic [1:0] IR_TRACE    = 2'b01;
  localparam logic [1:0] IR_BREAK    = 2'b10;
  localparam logic [1:0] IR_TRACEMEM = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_UIR  = 3'd1,
    ST_CDR  = 3'd2,
    ST_SDR  = 3'd3,
    ST_UDR  = 3'd4,
    ST_RTI  = 3'd5,
    ST_DONE = 3'd6
  } vjtag_state_e;

endpackage

// File: rtl/ltc5548_sys_debug_vjtag_tckgen.sv
// TCK phase counter: each period is a low half then a high half of TCK_DIV clks;
// rise/fall mark the clk on which the low/high half ends.
module ltc5548_sys_debug_vjtag_tckgen
  import ltc5548_sys_debug_vjtag_pkg::*;
#(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tck,
  output logic rise,
  output logic fall
);

  localparam int PH_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(TCK_DIV - 1);

  logic [PH_W-1:0] phase_r;
  logic            half_r;
  logic            last_s;

  assign last_s = (phase_r == PH_LAST);
  assign rise   = en && !half_r && last_s;
  assign fall   = en && half_r && last_s;
  assign tck    = half_r;

  // Phase/half counter, parked at the start of a low half while disabled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_r <= '0;
      half_r  <= 1'b0;
    end else if (!en) begin
      phase_r <= '0;
      half_r  <= 1'b0;
    end else if (last_s) begin
      phase_r <= '0;
      half_r  <= !half_r;
    end else begin
      phase_r <= phase_r + 1'b1;
    end
  end

endmodule

// File: rtl/ltc5548_sys_debug_vjtag_master.sv
// Virtual-JTAG initiator: runs UIR/CDR/SDR/UDR/RTI for one command and returns
// the DR bits shifted out of the debug slave plus its sampled ir_out.
module ltc5548_sys_debug_vjtag_master
  import ltc5548_sys_debug_vjtag_pkg::*;
#(
  parameter int DR_WIDTH   = DEF_DR_WIDTH,
  parameter int IR_WIDTH   = DEF_IR_WIDTH,
  parameter int TCK_DIV    = 2,
  parameter int RTI_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int BIT_W = $clog2(DR_WIDTH + 1);
  localparam int RTI_W = (RTI_CYCLES > 1) ? $clog2(RTI_CYCLES) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DR_WIDTH - 1);
  localparam logic [RTI_W-1:0] RTI_LAST = RTI_W'(RTI_CYCLES - 1);

  vjtag_state_e        state_r, state_s;
  logic [DR_WIDTH-1:0] shreg_r, shreg_s;
  logic [BIT_W-1:0]    bitcnt_r, bitcnt_s;
  logic [RTI_W-1:0]    rti_cnt_r, rti_cnt_s;
  logic                tdo_cap_r, tdo_cap_s;
  logic [IR_WIDTH-1:0] ir_in_r, ir_in_s;
  logic [IR_WIDTH-1:0] ir_out_r, ir_out_s;
  logic                cmd_ready_r, rsp_valid_r, tdi_r;
  logic [DR_WIDTH-1:0] rsp_dr_r;
  logic                uir_r, cdr_r, sdr_r, udr_r, rti_r;
  logic                tck_en_s, rise_s, fall_s;

  assign tck_en_s = (state_r != ST_IDLE) && (state_r != ST_DONE);

  ltc5548_sys_debug_vjtag_tckgen #(.TCK_DIV(TCK_DIV)) u_tckgen (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (tck_en_s),
    .tck     (vji_tck),
    .rise    (rise_s),
    .fall    (fall_s)
  );

  // Next-state, shift register and capture logic
  always_comb begin
    state_s   = state_r;
    shreg_s   = shreg_r;
    bitcnt_s  = bitcnt_r;
    rti_cnt_s = rti_cnt_r;
    tdo_cap_s = tdo_cap_r;
    ir_in_s   = ir_in_r;
    ir_out_s  = ir_out_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_r) begin
          ir_in_s   = cmd_ir;
          shreg_s   = cmd_dr;
          bitcnt_s  = '0;
          rti_cnt_s = '0;
          state_s   = ST_UIR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_UIR: begin
        if (rise_s) ir_out_s = vji_ir_out;
        else        ir_out_s = ir_out_r;
        if (fall_s) state_s = ST_CDR;
        else        state_s = ST_UIR;
      end
      ST_CDR: begin
        if (fall_s) state_s = ST_SDR;
        else        state_s = ST_CDR;
      end
      ST_SDR: begin
        if (rise_s) tdo_cap_s = vji_tdo;
        else        tdo_cap_s = tdo_cap_r;
        // rise and fall never coincide, so tdo_cap_r is this period's sample
        if (fall_s) begin
          shreg_s  = {tdo_cap_r, shreg_r[DR_WIDTH-1:1]};
          bitcnt_s = bitcnt_r + 1'b1;
          if (bitcnt_r == BIT_LAST) state_s = ST_UDR;
          else                      state_s = ST_SDR;
        end else begin
          state_s = ST_SDR;
        end
      end
      ST_UDR: begin
        if (fall_s) state_s = ST_RTI;
        else        state_s = ST_UDR;
      end
      ST_RTI: begin
        if (fall_s) begin
          rti_cnt_s = rti_cnt_r + 1'b1;
          if (rti_cnt_r == RTI_LAST) state_s = ST_DONE;
          else                       state_s = ST_RTI;
        end else begin
          state_s = ST_RTI;
        end
      end
      ST_DONE: begin
        if (rsp_valid_r && rsp_ready) state_s = ST_IDLE;
        else                          state_s = ST_DONE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs derived from the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      shreg_r     <= '0;
      bitcnt_r    <= '0;
      rti_cnt_r   <= '0;
      tdo_cap_r   <= 1'b0;
      ir_in_r     <= '0;
      ir_out_r    <= '0;
      cmd_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_dr_r    <= '0;
      tdi_r       <= 1'b0;
      uir_r       <= 1'b0;
      cdr_r       <= 1'b0;
      sdr_r       <= 1'b0;
      udr_r       <= 1'b0;
      rti_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      shreg_r     <= shreg_s;
      bitcnt_r    <= bitcnt_s;
      rti_cnt_r   <= rti_cnt_s;
      tdo_cap_r   <= tdo_cap_s;
      ir_in_r     <= ir_in_s;
      ir_out_r    <= ir_out_s;
      cmd_ready_r <= (state_s == ST_IDLE);
      rsp_valid_r <= (state_s == ST_DONE);
      rsp_dr_r    <= (state_s == ST_DONE) ? shreg_s : '0;
      tdi_r       <= (state_s == ST_SDR) && shreg_s[0];
      uir_r       <= (state_s == ST_UIR);
      cdr_r       <= (state_s == ST_CDR);
      sdr_r       <= (state_s == ST_SDR);
      udr_r       <= (state_s == ST_UDR);
      rti_r       <= (state_s == ST_RTI);
    end
  end

  assign cmd_ready  = cmd_ready_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_dr     = rsp_dr_r;
  assign rsp_ir_out = ir_out_r;
  assign vji_ir_in  = ir_in_r;
  assign vji_tdi    = tdi_r;
  assign vji_uir    = uir_r;
  assign vji_cdr    = cdr_r;
  assign vji_sdr    = sdr_r;
  assign vji_udr    = udr_r;
  assign vji_rti    = rti_r;

endmodule

// File: tb/tb_ltc5548_sys_debug_vjtag_master.sv
// Scoreboard bench: two initiators (default timing, and TCK_DIV=1/RTI_CYCLES=3)
// each talking to a 38-bit shift-register model of the debug slave.
module tb_ltc5548_sys_debug_vjtag_master;
  import ltc5548_sys_debug_vjtag_pkg::*;

  typedef struct {
    logic [37:0] dr;
    logic [1:0]  ir_out;
    logic [1:0]  ir_in;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT0: default parameters
  logic        cmd_valid0, cmd_ready0, rsp_valid0, rsp_ready0;
  logic [1:0]  cmd_ir0, rsp_ir_out0, vji_ir_in0, vji_ir_out0;
  logic [37:0] cmd_dr0, rsp_dr0;
  logic        vji_tck0, vji_tdi0, vji_tdo0, vji_uir0, vji_cdr0, vji_sdr0, vji_udr0, vji_rti0;
  // DUT1: fast TCK, long run-test-idle
  logic        cmd_valid1, cmd_ready1, rsp_valid1, rsp_ready1;
  logic [1:0]  cmd_ir1, rsp_ir_out1, vji_ir_in1, vji_ir_out1;
  logic [37:0] cmd_dr1, rsp_dr1;
  logic        vji_tck1, vji_tdi1, vji_tdo1, vji_uir1, vji_cdr1, vji_sdr1, vji_udr1, vji_rti1;

  ltc5548_sys_debug_vjtag_master u_dut0 (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_ir(cmd_ir0), .cmd_dr(cmd_dr0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_dr(rsp_dr0), .rsp_ir_out(rsp_ir_out0),
    .vji_ir_in(vji_ir_in0), .vji_tck(vji_tck0), .vji_tdi(vji_tdi0), .vji_tdo(vji_tdo0),
    .vji_ir_out(vji_ir_out0), .vji_uir(vji_uir0), .vji_cdr(vji_cdr0), .vji_sdr(vji_sdr0),
    .vji_udr(vji_udr0), .vji_rti(vji_rti0)
  );

  ltc5548_sys_debug_vjtag_master #(.TCK_DIV(1), .RTI_CYCLES(3)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_ir(cmd_ir1), .cmd_dr(cmd_dr1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_dr(rsp_dr1), .rsp_ir_out(rsp_ir_out1),
    .vji_ir_in(vji_ir_in1), .vji_tck(vji_tck1), .vji_tdi(vji_tdi1), .vji_tdo(vji_tdo1),
    .vji_ir_out(vji_ir_out1), .vji_uir(vji_uir1), .vji_cdr(vji_cdr1), .vji_sdr(vji_sdr1),
    .vji_udr(vji_udr1), .vji_rti(vji_rti1)
  );

  // Slave models: capture at CDR, shift LSB-first during SDR on TCK rise
  logic [37:0] slave0_sr = 38'd0, slave0_cap = 38'd0;
  logic [37:0] slave1_sr = 38'd0, slave1_cap = 38'd0;
  assign vji_tdo0 = slave0_sr[0];
  assign vji_tdo1 = slave1_sr[0];

  always @(posedge vji_tck0) begin
    if (vji_cdr0)      slave0_sr <= slave0_cap;
    else if (vji_sdr0) slave0_sr <= {vji_tdi0, slave0_sr[37:1]};
  end

  always @(posedge vji_tck1) begin
    if (vji_cdr1)      slave1_sr <= slave1_cap;
    else if (vji_sdr1) slave1_sr <= {vji_tdi1, slave1_sr[37:1]};
  end

  wire [50:0] out0_all = {cmd_ready0, rsp_valid0, rsp_dr0, rsp_ir_out0, vji_ir_in0, vji_tck0,
                          vji_tdi0, vji_uir0, vji_cdr0, vji_sdr0, vji_udr0, vji_rti0};
  wire [50:0] out1_all = {cmd_ready1, rsp_valid1, rsp_dr1, rsp_ir_out1, vji_ir_in1, vji_tck1,
                          vji_tdi1, vji_uir1, vji_cdr1, vji_sdr1, vji_udr1, vji_rti1};

  exp_t        exp0_q[$], exp1_q[$];
  int          acc0_q[$], acc1_q[$];
  logic [37:0] udr0_q[$], udr1_q[$];
  int          bp_cycles = 0;
  int          hs_edge = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event occurred, required none", name);
  endtask

  task automatic send(input int which, input logic [1:0] ir, input logic [37:0] dr, output int acc);
    acc = -1;
    @(negedge clk);
    if (which == 0) begin cmd_valid0 = 1'b1; cmd_ir0 = ir; cmd_dr0 = dr; end
    else            begin cmd_valid1 = 1'b1; cmd_ir1 = ir; cmd_dr1 = dr; end
    for (int n = 0; n < 1000; n++) begin
      if ((which == 0 && cmd_ready0) || (which == 1 && cmd_ready1)) begin
        acc = cyc + 1;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) flag_fail("accept_timeout");
    else if (which == 0) acc0_q.push_back(acc);
    else acc1_q.push_back(acc);
    @(negedge clk);
    cmd_valid0 = 1'b0;
    cmd_valid1 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp0_q.size() != 0 || exp1_q.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) flag_fail("response_timeout");
    repeat (3) @(negedge clk);
  endtask

  // DUT0 monitor: strobe accounting, response scoreboard, rsp_ready backpressure
  int   m0_uir, m0_cdr, m0_sdr, m0_udr, m0_rti, m0_rise, m0_hold;
  logic m0_tck_prev, m0_overlap, m0_tdi_bad, m0_seen, m0_unstable, m0_rdy_bad;
  logic [37:0] m0_first_dr;
  initial begin
    exp_t e;
    int   a;
    rsp_ready0 = 1'b1;
    m0_seen = 1'b0; m0_tck_prev = 1'b0; m0_hold = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready0) begin
        m0_uir = 0; m0_cdr = 0; m0_sdr = 0; m0_udr = 0; m0_rti = 0; m0_rise = 0;
        m0_overlap = 1'b0; m0_tdi_bad = 1'b0;
      end else begin
        m0_uir += int'(vji_uir0); m0_cdr += int'(vji_cdr0); m0_sdr += int'(vji_sdr0);
        m0_udr += int'(vji_udr0); m0_rti += int'(vji_rti0);
        if (vji_tck0 && !m0_tck_prev) m0_rise++;
      end
      if ($countones({vji_uir0, vji_cdr0, vji_sdr0, vji_udr0, vji_rti0}) > 1) m0_overlap = 1'b1;
      if (!vji_sdr0 && vji_tdi0) m0_tdi_bad = 1'b1;
      m0_tck_prev = vji_tck0;
      if (rsp_valid0) begin
        if (!m0_seen) begin
          m0_seen = 1'b1; m0_hold = 0; m0_first_dr = rsp_dr0;
          m0_unstable = 1'b0; m0_rdy_bad = 1'b0;
          if (exp0_q.size() == 0 || acc0_q.size() == 0) begin
            flag_fail("unexpected_rsp0");
          end else begin
            e = exp0_q.pop_front();
            a = acc0_q.pop_front();
            chk("latency0", 64'(cyc - a), 64'd168);
            chk("rsp_dr0", 64'(rsp_dr0), 64'(e.dr));
            chk("rsp_ir_out0", 64'(rsp_ir_out0), 64'(e.ir_out));
            chk("vji_ir_in0", 64'(vji_ir_in0), 64'(e.ir_in));
            chk("uir_width0", 64'(m0_uir), 64'd4);
            chk("cdr_width0", 64'(m0_cdr), 64'd4);
            chk("sdr_width0", 64'(m0_sdr), 64'd152);
            chk("udr_width0", 64'(m0_udr), 64'd4);
            chk("rti_width0", 64'(m0_rti), 64'd4);
            chk("tck_rises0", 64'(m0_rise), 64'd42);
            chk("strobe_overlap0", 64'(m0_overlap), 64'd0);
            chk("tdi_outside_sdr0", 64'(m0_tdi_bad), 64'd0);
          end
        end else if (rsp_dr0 !== m0_first_dr) begin
          m0_unstable = 1'b1;
        end
        if (cmd_ready0) m0_rdy_bad = 1'b1;
        if (m0_hold >= bp_cycles) begin
          rsp_ready0 = 1'b1;
          chk("rsp_dr_stable0", 64'(m0_unstable), 64'd0);
          chk("cmd_ready_in_done0", 64'(m0_rdy_bad), 64'd0);
          hs_edge = cyc + 1;
          m0_seen = 1'b0;
        end else begin
          rsp_ready0 = 1'b0;
          m0_hold++;
        end
      end else begin
        rsp_ready0 = 1'b1;
      end
    end
  end

  // DUT1 monitor: always ready, so every rsp_valid cycle is one response
  int   m1_rise;
  logic m1_tck_prev, m1_act_prev, m1_no_toggle;
  initial begin
    exp_t e;
    int   a;
    logic act;
    rsp_ready1 = 1'b1;
    m1_tck_prev = 1'b0; m1_act_prev = 1'b0;
    forever begin
      @(negedge clk);
      act = vji_uir1 | vji_cdr1 | vji_sdr1 | vji_udr1 | vji_rti1;
      if (cmd_ready1) begin
        m1_rise = 0; m1_no_toggle = 1'b0;
      end else begin
        if (vji_tck1 && !m1_tck_prev) m1_rise++;
        if (act && m1_act_prev && vji_tck1 == m1_tck_prev) m1_no_toggle = 1'b1;
      end
      m1_tck_prev = vji_tck1;
      m1_act_prev = act;
      if (rsp_valid1) begin
        if (exp1_q.size() == 0 || acc1_q.size() == 0) begin
          flag_fail("unexpected_rsp1");
        end else begin
          e = exp1_q.pop_front();
          a = acc1_q.pop_front();
          chk("latency1", 64'(cyc - a), 64'd88);
          chk("rsp_dr1", 64'(rsp_dr1), 64'(e.dr));
          chk("rsp_ir_out1", 64'(rsp_ir_out1), 64'(e.ir_out));
          chk("tck_rises1", 64'(m1_rise), 64'd44);
          chk("tck_toggle1", 64'(m1_no_toggle), 64'd0);
        end
      end
    end
  end

  // Slave contents at UDR must equal the command DR
  initial forever begin
    @(posedge vji_udr0);
    if (udr0_q.size() == 0) flag_fail("unexpected_udr0");
    else chk("slave_at_udr0", 64'(slave0_sr), 64'(udr0_q.pop_front()));
  end

  initial forever begin
    @(posedge vji_udr1);
    if (udr1_q.size() == 0) flag_fail("unexpected_udr1");
    else chk("slave_at_udr1", 64'(slave1_sr), 64'(udr1_q.pop_front()));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    int a1, a2, a3, a4, a5, b1, b2, n;
    reset_n = 1'b0;
    cmd_valid0 = 1'b0; cmd_ir0 = 2'b00; cmd_dr0 = 38'd0;
    cmd_valid1 = 1'b0; cmd_ir1 = 2'b00; cmd_dr1 = 38'd0;
    vji_ir_out0 = 2'b10; vji_ir_out1 = 2'b01;
    repeat (5) @(negedge clk);
    chk("reset_outputs0", 64'(out0_all), 64'd0);
    chk("reset_outputs1", 64'(out1_all), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_reset0", 64'(cmd_ready0), 64'd1);
    chk("cmd_ready_after_reset1", 64'(cmd_ready1), 64'd1);
    chk("tck_idle0", 64'(vji_tck0), 64'd0);

    // Single transaction
    slave0_cap = 38'h15_1234_5678;
    exp0_q.push_back('{dr: 38'h15_1234_5678, ir_out: 2'b10, ir_in: IR_TRACE});
    udr0_q.push_back(38'h2A_DEAD_BEEF);
    send(0, IR_TRACE, 38'h2A_DEAD_BEEF, a1);
    drain();

    // Backpressure with the next command already waiting
    vji_ir_out0 = 2'b11;
    slave0_cap = 38'h3F_0000_FFFF;
    bp_cycles = 10;
    exp0_q.push_back('{dr: 38'h3F_0000_FFFF, ir_out: 2'b11, ir_in: IR_BREAK});
    udr0_q.push_back(38'h01_8421_1248);
    exp0_q.push_back('{dr: 38'h3F_0000_FFFF, ir_out: 2'b11, ir_in: IR_OCIMEM});
    udr0_q.push_back(38'h3E_7BDE_EDB7);
    send(0, IR_BREAK, 38'h01_8421_1248, a2);
    send(0, IR_OCIMEM, 38'h3E_7BDE_EDB7, a3);
    chk("accept_after_handshake", 64'(a3), 64'(hs_edge + 1));
    bp_cycles = 0;
    drain();

    // Reset in the middle of SDR, then a clean transaction
    slave0_cap = 38'h2B_CAFE_F00D;
    send(0, IR_TRACEMEM, 38'h11_1111_1111, a4);
    n = 0;
    while (cyc < a4 + 50 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("sdr_before_reset", 64'(vji_sdr0), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_outputs0", 64'(out0_all), 64'd0);
    acc0_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    exp0_q.push_back('{dr: 38'h2B_CAFE_F00D, ir_out: 2'b11, ir_in: IR_TRACE});
    udr0_q.push_back(38'h0C_3A5A_5A5A);
    send(0, IR_TRACE, 38'h0C_3A5A_5A5A, a5);
    drain();

    // Fast TCK instance: all-ones / all-zeros round trips
    slave1_cap = 38'd0;
    exp1_q.push_back('{dr: 38'd0, ir_out: 2'b01, ir_in: IR_OCIMEM});
    udr1_q.push_back({38{1'b1}});
    send(1, IR_OCIMEM, {38{1'b1}}, b1);
    drain();
    slave1_cap = {38{1'b1}};
    exp1_q.push_back('{dr: {38{1'b1}}, ir_out: 2'b01, ir_in: IR_BREAK});
    udr1_q.push_back(38'd0);
    send(1, IR_BREAK, 38'd0, b2);
    drain();

    if (udr0_q.size() != 0 || udr1_q.size() != 0) flag_fail("udr_not_reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ltc5548_sys_debug_vjtag_master.md
Name: ltc5548_sys_debug_vjtag_master

Overview:
- Initiator side of the Nios II debug slave's virtual-JTAG interface.
- Runs complete virtual-JTAG transactions from a simple command/response handshake: IR load, DR capture, DR shift, DR update, run-test-idle.
- Drives the ir_in/tck/tdi/state strobes that the debug slave consumes and collects its tdo and ir_out.
- Used for in-system self-test and for simulation benches of the debug slave, where the real JTAG hub is absent.

Parameters:
- DR_WIDTH, 38: data-register length in bits; matches the debug slave's sr/jdo width.
- IR_WIDTH, 2: virtual IR width.
- TCK_DIV, 2: TCK half-period in clk cycles (legal values ≥1).
- RTI_CYCLES, 1: TCK periods spent in run-test-idle after update (legal values ≥1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous reset, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
- cmd_ir  in  IR_WIDTH  IR value to load.
- cmd_dr  in  DR_WIDTH  DR value to shift in.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready.
- rsp_dr  out  DR_WIDTH  DR bits shifted out of the slave.
- rsp_ir_out  out  IR_WIDTH  slave ir_out sampled during UIR.
- vji_ir_in  out  IR_WIDTH  IR to slave.
- vji_tck  out  1  generated TCK.
- vji_tdi  out  1  serial data to slave.
- vji_tdo  in  1  serial data from slave.
- vji_ir_out  in  IR_WIDTH  slave IR status.
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  virtual-state strobes.

Behaviour:
- Reset:
  - All outputs are 0 and state is IDLE.
  - Asserting reset_n low mid-transaction aborts it immediately: strobes and tck go to 0, no response is produced, and the shift register is cleared.
- TCK phase counter:
  - Counts 0..TCK_DIV-1 per half-period and runs only outside IDLE/DONE.
  - Each TCK period is a low half followed by a high half.
  - "rise" = the clk on which the low half ends; "fall" = the clk on which the high half ends.
  - vji_tck is low in IDLE/DONE.
- States: IDLE → UIR → CDR → SDR → UDR → RTI → DONE → IDLE.
  - IDLE:
    - cmd_ready=1.
    - On accept: latch cmd_ir into vji_ir_in and cmd_dr into shreg, clear the bit counter, go to UIR.
  - UIR:
    - 1 TCK period; vji_uir=1.
    - At rise, capture vji_ir_out into rsp_ir_out.
  - CDR: 1 TCK period; vji_cdr=1.
  - SDR:
    - DR_WIDTH TCK periods; vji_sdr=1.
    - vji_tdi = shreg[0] throughout each period.
    - At rise, sample vji_tdo into tdo_cap.
    - At fall, shreg <= {tdo_cap, shreg[DR_WIDTH-1:1]} and the bit counter increments.
    - Leave SDR at the fall where the counter reaches DR_WIDTH-1.
  - UDR: 1 TCK period; vji_udr=1.
  - RTI: RTI_CYCLES TCK periods; vji_rti=1.
  - DONE:
    - rsp_valid=1, rsp_dr=shreg.
    - Both hold stable until rsp_ready, then return to IDLE on the following clk.
- State transitions occur only at fall, except IDLE→UIR (on accept) and DONE→IDLE (on rsp handshake).
- At most one strobe is high in any cycle.
- vji_tdi is 0 outside SDR.
- vji_ir_in holds its last loaded value until the next accept.
- cmd_ready=0 in every state except IDLE; a command is never accepted while a response is pending.
- Latency: rsp_valid rises exactly (3+DR_WIDTH+RTI_CYCLES)*2*TCK_DIV clk cycles after the accept cycle.
- Bit order: the first bit shifted is cmd_dr[0]; the first bit received lands in rsp_dr[0].
- rsp_ready held high in IDLE has no effect. cmd_valid asserted during a transaction is ignored until IDLE.

Decomposition:
- Shared package ltc5548_sys_debug_vjtag_pkg holds:
  - the state enum;
  - default DR_WIDTH/IR_WIDTH constants;
  - named IR codes for the debug slave (2'b00 ocimem, 2'b01 trace, 2'b10 break, 2'b11 tracemem/status).
- Sub-module: ltc5548_sys_debug_vjtag_tckgen, the TCK phase counter producing vji_tck, rise and fall, with an enable input.
- The state machine and shift register stay in the top module.

Test Plan:
- Reset values: hold reset_n=0 for 5 cycles → every output 0 and cmd_ready=0; release reset_n → cmd_ready=1 one cycle later, tck stays 0.
- Single transaction with a bench slave model (38-bit shift register, tdo=sr[0]):
  - Setup: defaults, slave preloaded 38'h15_1234_5678, slave ir_out=2'b10; send cmd_ir=2'b01, cmd_dr=38'h2A_DEAD_BEEF.
  - Required response: rsp_valid exactly 168 cycles after accept; rsp_dr=38'h15_1234_5678; rsp_ir_out=2'b10; slave holds 38'h2A_DEAD_BEEF at UDR.
- Strobe widths with TCK_DIV=2:
  - vji_uir, vji_cdr, vji_udr and vji_rti are each high for exactly 4 cycles; vji_sdr is high for 152 cycles; vji_tck shows 42 rising edges.
  - No overlapping strobes anywhere in the transaction.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid while cmd_valid=1 → rsp_dr stable and cmd_ready=0 throughout; the next command is accepted the cycle after the response handshake completes IDLE.
- Reset mid-SDR: pull reset_n low after 10 bits have been shifted → all outputs are 0 in the same cycle; after release, a fresh transaction completes with correct data and no stale response.
- TCK_DIV=1, RTI_CYCLES=3: vji_tck toggles every clk during the transaction; rsp_valid arrives 88 cycles after accept; the all-ones/all-zeros DR pattern round-trips bit-exact.
